coin_detector: RTL

- Front-end stage directly upstream of the vending-machine FSM. Converts three raw, asynchronous, bouncy coin-sensor lines into clean single-cycle nickel/dime/quarter pulses. These pulses drive the FSM coin inputs.
- Synchronizes and debounces the sensor lines and accepts one coin at a time. Rejects simultaneous or overlapping coins.
- Requires the coin path to go quiet before another coin is accepted, so the FSM never sees a double count.

---
 rtl/coin_detector.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/coin_detector.sv
// rtl/coin_detector.sv - synchronize, debounce and qualify three coin sensors into clean one-cycle pulses
module coin_detector #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic nickel_raw_i,
  input  logic dime_raw_i,
  input  logic quarter_raw_i,
  input  logic enable_i,
  output logic nickel_o,
  output logic dime_o,
  output logic quarter_o,
  output logic reject_o,
  output logic busy_o
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    QUAL     = 3'd1,
    EMIT     = 3'd2,
    REJECT   = 3'd3,
    WAIT_REL = 3'd4
  } state_t;

  logic [SYNC_STAGES-1:0] n_sync_q;
  logic [SYNC_STAGES-1:0] d_sync_q;
  logic [SYNC_STAGES-1:0] q_sync_q;

  // Synced lines packed as {quarter, dime, nickel}; the coin id uses the same one-hot layout.
  logic [2:0] s_lines;
  logic       any_line;
  logic       multi_line;

  state_t     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0] id_q, id_d;

  logic nickel_d, dime_d, quarter_d, reject_d, busy_d;
  logic nickel_q, dime_q, quarter_q, reject_q, busy_q;

  // Per-line synchronizer chains; only the last stage is used downstream.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      n_sync_q <= '0;
      d_sync_q <= '0;
      q_sync_q <= '0;
    end else begin
      n_sync_q <= {n_sync_q[SYNC_STAGES-2:0], nickel_raw_i};
      d_sync_q <= {d_sync_q[SYNC_STAGES-2:0], dime_raw_i};
      q_sync_q <= {q_sync_q[SYNC_STAGES-2:0], quarter_raw_i};
    end
  end

  // Summaries of the synced lines used by the qualifier.
  always_comb begin
    s_lines    = {q_sync_q[SYNC_STAGES-1], d_sync_q[SYNC_STAGES-1], n_sync_q[SYNC_STAGES-1]};
    any_line   = |s_lines;
    multi_line = (s_lines[0] & s_lines[1]) | (s_lines[0] & s_lines[2]) | (s_lines[1] & s_lines[2]);
  end

  // State, counter and coin-id registers; reset parks in WAIT_REL so a held coin must be released first.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= WAIT_REL;
      cnt_q   <= '0;
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      id_q    <= id_d;
    end
  end

  // Next-state logic: qualify one coin, reject overlaps, then demand a quiet interval.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    id_d    = id_q;
    case (state_q)
      IDLE: begin
        if (multi_line) begin
          state_d = REJECT;
        end else if (any_line) begin
          id_d    = s_lines;
          cnt_d   = CNT_ONE;
          state_d = QUAL;
        end
      end
      QUAL: begin
        if (|(s_lines & ~id_q)) begin
          state_d = REJECT;
        end else if (!(|(s_lines & id_q))) begin
          state_d = IDLE;
        end else if (cnt_q == CNT_MAX) begin
          state_d = EMIT;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      EMIT, REJECT: begin
        state_d = WAIT_REL;
        cnt_d   = '0;
      end
      WAIT_REL: begin
        if (any_line) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = WAIT_REL;
        cnt_d   = '0;
      end
    endcase
  end

  // Output decode from the next state; enable_i matters only on the edge that enters EMIT.
  always_comb begin
    nickel_d  = (state_d == EMIT) && enable_i && id_q[0];
    dime_d    = (state_d == EMIT) && enable_i && id_q[1];
    quarter_d = (state_d == EMIT) && enable_i && id_q[2];
    reject_d  = (state_d == REJECT) || ((state_d == EMIT) && !enable_i);
    busy_d    = (state_d != IDLE);
  end

  // Registered outputs, updated on the same edge as the state they decode.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      nickel_q  <= 1'b0;
      dime_q    <= 1'b0;
      quarter_q <= 1'b0;
      reject_q  <= 1'b0;
      busy_q    <= 1'b1;
    end else begin
      nickel_q  <= nickel_d;
      dime_q    <= dime_d;
      quarter_q <= quarter_d;
      reject_q  <= reject_d;
      busy_q    <= busy_d;
    end
  end

  assign nickel_o  = nickel_q;
  assign dime_o    = dime_q;
  assign quarter_o = quarter_q;
  assign reject_o  = reject_q;
  assign busy_o    = busy_q;

endmodule
